// File: rtl/cache_refill_ctrl_pkg.sv
// Shared widths and the controller state encoding for the cache refill controller.
package cache_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ADDR_WIDTH   = 16;
    localparam int TAG_WIDTH    = 10;
    localparam int OFFSET_WIDTH = 2;
    localparam int INDEX_WIDTH  = ADDR_WIDTH - TAG_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        WRITE,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } ctrl_state_t;

endpackage

// File: rtl/cache_refill_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Request sequencer between the CPU, the inner cache and backing memory:
// read-miss refill, write-through/write-allocate, saturating hit/miss statistics.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH   = cache_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = cache_pkg::ADDR_WIDTH,
    parameter int TAG_WIDTH    = cache_pkg::TAG_WIDTH,
    parameter int OFFSET_WIDTH = cache_pkg::OFFSET_WIDTH,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_we,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    input  logic                  cache_miss,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    import cache_pkg::*;

    // Tag plus offset must leave at least one index bit.
    if (TAG_WIDTH + OFFSET_WIDTH >= ADDR_WIDTH) begin : g_bad_geometry
        $error("cache_refill_ctrl: TAG_WIDTH + OFFSET_WIDTH must be below ADDR_WIDTH");
    end

    ctrl_state_t           state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [ADDR_WIDTH-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_WIDTH-1:0] cache_wdata_q, cache_wdata_d;
    logic                  cache_we_q, cache_we_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  req_we_q, req_we_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hit_inc;
    logic                  miss_inc;

    // Outputs are computed for the state being entered, so every port is a flop.
    always_comb begin
        state_d         = state_q;
        ready_d         = ready_q;
        resp_valid_d    = 1'b0;
        cpu_rdata_d     = cpu_rdata_q;
        cache_addr_d    = cache_addr_q;
        cache_wdata_d   = cache_wdata_q;
        cache_we_d      = 1'b0;
        mem_req_valid_d = 1'b0;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        req_we_d        = req_we_q;
        req_addr_d      = req_addr_q;
        req_wdata_d     = req_wdata_q;
        data_d          = data_q;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (cpu_req_valid && ready_q) begin
                    ready_d      = 1'b0;
                    req_we_d     = cpu_we;
                    req_addr_d   = cpu_addr;
                    req_wdata_d  = cpu_wdata;
                    cache_addr_d = cpu_addr;
                    if (cpu_we) begin
                        state_d       = WRITE;
                        cache_we_d    = 1'b1;
                        cache_wdata_d = cpu_wdata;
                    end else begin
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (cache_hit) begin
                    hit_inc      = 1'b1;
                    data_d       = cache_rdata;
                    cpu_rdata_d  = cache_rdata;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    // Neither flag set still counts as a miss.
                    miss_inc        = cache_miss | ~cache_hit;
                    mem_req_valid_d = 1'b1;
                    mem_we_d        = 1'b0;
                    mem_addr_d      = req_addr_q;
                    state_d         = MEM_REQ;
                end
            end
            WRITE: begin
                mem_req_valid_d = 1'b1;
                mem_we_d        = 1'b1;
                mem_addr_d      = req_addr_q;
                mem_wdata_d     = req_wdata_q;
                state_d         = MEM_REQ;
            end
            MEM_REQ: begin
                mem_req_valid_d = 1'b1;
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    if (req_we_q) begin
                        cpu_rdata_d  = req_wdata_q;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        data_d        = mem_rdata;
                        cache_we_d    = 1'b1;
                        cache_addr_d  = req_addr_q;
                        cache_wdata_d = mem_rdata;
                        state_d       = FILL;
                    end
                end
            end
            FILL: begin
                cpu_rdata_d  = data_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ready_q         <= 1'b1;
            resp_valid_q    <= 1'b0;
            cpu_rdata_q     <= '0;
            cache_addr_q    <= '0;
            cache_wdata_q   <= '0;
            cache_we_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            req_we_q        <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            data_q          <= '0;
        end else begin
            state_q         <= state_d;
            ready_q         <= ready_d;
            resp_valid_q    <= resp_valid_d;
            cpu_rdata_q     <= cpu_rdata_d;
            cache_addr_q    <= cache_addr_d;
            cache_wdata_q   <= cache_wdata_d;
            cache_we_q      <= cache_we_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            req_we_q        <= req_we_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            data_q          <= data_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (miss_count)
    );

    assign cpu_req_ready  = ready_q;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign cache_addr     = cache_addr_q;
    assign cache_wdata    = cache_wdata_q;
    assign cache_we       = cache_we_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule
